// File: rtl/uart_pkg.sv
// Shared definitions for the debug UART receive path: frame width, receiver
// FSM states and the bit-period calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_e;

  function automatic int calc_clks_per_bit(input int sys_clk_freq, input int baud_rate);
    return sys_clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_dbg_rx_if.sv
// Pop-side bus of the debug UART receiver: read strobe, popped byte and FIFO
// status. The slave side is the receiver, the master side is the consumer.
interface uart_dbg_rx_if;

  logic                           rd;
  logic [uart_pkg::DATA_BITS-1:0] data_out;
  logic                           rd_valid;
  logic                           empty;
  logic                           full;

  modport slave  (input  rd, output data_out, output rd_valid, output empty, output full);
  modport master (output rd, input  data_out, input  rd_valid, input  empty, input  full);

endinterface

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with occupancy counter; writes when full and
// reads when empty are ignored. Pointers wrap naturally (DEPTH is a power of 2).
module fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wr_ok_s, rd_ok_s;

  assign empty   = (count_q == {(PTR_W + 1){1'b0}});
  assign full    = (count_q == DEPTH_C);
  assign wr_ok_s = wr_en & ~full;
  assign rd_ok_s = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so it has no reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 deserialiser: 2-flop rx synchroniser, mid-bit sampling FSM and LSB-first
// shift register. valid/frame_err are single-cycle pulses in the stop-sample cycle.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_receiver: CLKS_PER_BIT must be at least 4");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  assign data = shift_q;
  assign busy = (state_q != IDLE);

  // Next-state, counter, shift register and stop-bit pulses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid     = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // Re-check the line half a bit in so short glitches are rejected.
        if (cnt_q == HALF_M1) begin
          cnt_d     = {CNT_W{1'b0}};
          bit_idx_d = 3'd0;
          if (!rx_s_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = {CNT_W{1'b0}};
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = {CNT_W{1'b0}};
          if (rx_s_q) begin
            valid   = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BRK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BRK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = BRK;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Synchroniser (reset to idle-high) and FSM registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= {DATA_BITS{1'b0}};
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: rtl/uart_dbg_rx.sv
// Debug UART receive path: uart_receiver feeding a byte FIFO, with a registered
// pop port and one-cycle frame_err/overrun status pulses.
module uart_dbg_rx
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 48_000_000,
  parameter int BAUD_RATE    = 3_000_000,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  uart_dbg_rx_if.slave bus,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_dbg_rx: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [1:0]           rst_sync_q, rst_sync_d;
  logic                 rst_n_s;
  logic [DATA_BITS-1:0] rcv_data_s, fifo_rd_data_s;
  logic                 rcv_valid_s, rcv_frame_err_s, rcv_busy_s;
  logic                 fifo_wr_s, fifo_rd_s, fifo_empty_s, fifo_full_s;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  // Reset asserts immediately, releases two clocks after the pin deasserts.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchroniser flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_s = rst_sync_q[1];

  uart_receiver #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_receiver (
    .clk      (clk),
    .reset    (rst_n_s),
    .rx       (rx),
    .data     (rcv_data_s),
    .valid    (rcv_valid_s),
    .frame_err(rcv_frame_err_s),
    .busy     (rcv_busy_s)
  );

  // full is taken before any same-cycle pop, so a full FIFO refuses the write.
  assign fifo_wr_s = rcv_valid_s & ~fifo_full_s;
  assign fifo_rd_s = bus.rd & ~fifo_empty_s;

  fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk    (clk),
    .reset  (rst_n_s),
    .wr_en  (fifo_wr_s),
    .wr_data(rcv_data_s),
    .rd_en  (fifo_rd_s),
    .rd_data(fifo_rd_data_s),
    .empty  (fifo_empty_s),
    .full   (fifo_full_s)
  );

  // Pop port and status pulse next-state.
  always_comb begin
    data_out_d  = data_out_q;
    rd_valid_d  = fifo_rd_s;
    frame_err_d = rcv_frame_err_s;
    overrun_d   = rcv_valid_s & fifo_full_s;
    if (fifo_rd_s) begin
      data_out_d = fifo_rd_data_s;
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      data_out_q  <= {DATA_BITS{1'b0}};
      rd_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = fifo_empty_s;
  assign bus.full     = fifo_full_s;
  assign busy         = rcv_busy_s;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_dbg_rx.sv
// Directed bench for uart_dbg_rx at 16 clocks per bit with a 32-entry FIFO.
module tb_uart_dbg_rx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic busy, frame_err, overrun;

  uart_dbg_rx_if bus_if ();

  uart_dbg_rx #(
    .SYS_CLK_FREQ(48_000_000),
    .BAUD_RATE   (3_000_000),
    .FIFO_DEPTH  (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .bus      (bus_if),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int  n_pass = 0;
  int  n_total = 0;
  int  n_fail = 0;
  int  fe_cnt = 0;
  int  ov_cnt = 0;
  int  busy_falls = 0;
  logic prev_busy = 1'b0;
  logic prev_empty = 1'b1;
  time last_fall_t = 0;

  // Event monitor: counts status pulses and records when empty last fell.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (prev_busy === 1'b1 && busy === 1'b0) busy_falls <= busy_falls + 1;
    if (prev_empty === 1'b1 && bus_if.empty === 1'b0) last_fall_t <= $time;
    prev_busy  <= busy;
    prev_empty <= bus_if.empty;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    bus_if.rd = 1'b1;
    @(negedge clk);
    bus_if.rd = 1'b0;
    chk({tag, "_valid"}, {31'd0, bus_if.rd_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, bus_if.data_out}, {24'd0, exp});
  endtask

  initial begin
    time start_t;
    int  lat, fe0, ov0, bf0, busy_cyc;
    logic [7:0] mid_byte;

    reset = 1'b0;
    rx = 1'b1;
    bus_if.rd = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data_out", {24'd0, bus_if.data_out}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus_if.rd_valid}, 32'd0);
    chk("rst_empty", {31'd0, bus_if.empty}, 32'd1);
    chk("rst_full", {31'd0, bus_if.full}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame 0xA5: stop sample lands ~155 cycles after the start edge.
    start_t = $time;
    send_byte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    chk("a5_not_empty", {31'd0, bus_if.empty}, 32'd0);
    lat = int'((last_fall_t - start_t) / 10);
    chk("a5_latency_window", {31'd0, (lat >= 152 && lat <= 157)}, 32'd1);
    pop_chk("a5", 8'hA5);
    @(negedge clk);
    chk("a5_valid_one_cycle", {31'd0, bus_if.rd_valid}, 32'd0);
    chk("a5_empty_after", {31'd0, bus_if.empty}, 32'd1);

    // Read on empty is ignored.
    bus_if.rd = 1'b1;
    @(negedge clk);
    bus_if.rd = 1'b0;
    chk("rd_empty_no_valid", {31'd0, bus_if.rd_valid}, 32'd0);
    chk("rd_empty_data_held", {24'd0, bus_if.data_out}, 32'h0000_00A5);
    chk("rd_empty_still_empty", {31'd0, bus_if.empty}, 32'd1);

    // Back-to-back frames with no idle gap.
    fe0 = fe_cnt;
    bf0 = busy_falls;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    chk("b2b_no_frame_err", fe_cnt - fe0, 32'd0);
    chk("b2b_busy_falls", busy_falls - bf0, 32'd3);
    pop_chk("b2b0", 8'h00);
    pop_chk("b2b1", 8'hFF);
    pop_chk("b2b2", 8'h3C);

    // Fill the FIFO, then overrun it by one byte.
    ov0 = ov_cnt;
    for (int i = 1; i <= 32; i++) begin
      send_byte(8'(i), 1'b1);
    end
    repeat (2) @(negedge clk);
    chk("fill_full", {31'd0, bus_if.full}, 32'd1);
    chk("fill_no_overrun", ov_cnt - ov0, 32'd0);
    send_byte(8'h21, 1'b1);
    repeat (3) @(negedge clk);
    chk("ovr_one_pulse", ov_cnt - ov0, 32'd1);
    chk("ovr_still_full", {31'd0, bus_if.full}, 32'd1);
    for (int i = 1; i <= 32; i++) begin
      pop_chk($sformatf("drain%0d", i), 8'(i));
    end
    @(negedge clk);
    chk("drain_empty", {31'd0, bus_if.empty}, 32'd1);
    chk("drain_not_full", {31'd0, bus_if.full}, 32'd0);

    // Stop bit low followed by a held break.
    fe0 = fe_cnt;
    send_byte(8'h55, 1'b0);
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("brk_one_frame_err", fe_cnt - fe0, 32'd1);
    chk("brk_fifo_empty", {31'd0, bus_if.empty}, 32'd1);
    send_byte(8'h77, 1'b1);
    repeat (2) @(negedge clk);
    pop_chk("after_brk", 8'h77);

    // 3-cycle glitch on idle line.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    busy_cyc = 0;
    rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
    end
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
    end
    chk("glitch_busy_short", {31'd0, (busy_cyc >= 1 && busy_cyc <= 10)}, 32'd1);
    chk("glitch_no_frame_err", fe_cnt - fe0, 32'd0);
    chk("glitch_no_overrun", ov_cnt - ov0, 32'd0);
    chk("glitch_empty", {31'd0, bus_if.empty}, 32'd1);

    // Reset during bit 4 with two bytes queued.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    chk("pre_rst_not_empty", {31'd0, bus_if.empty}, 32'd0);
    mid_byte = 8'h99;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = mid_byte[i];
      repeat (CPB) @(negedge clk);
    end
    rx = mid_byte[4];
    repeat (CPB / 2) @(negedge clk);
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_empty", {31'd0, bus_if.empty}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data_out", {24'd0, bus_if.data_out}, 32'd0);
    chk("mid_rst_rd_valid", {31'd0, bus_if.rd_valid}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h12, 1'b1);
    repeat (2) @(negedge clk);
    pop_chk("post_rst", 8'h12);
    @(negedge clk);
    chk("post_rst_empty", {31'd0, bus_if.empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
